// File: rtl/uart_tx_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_drain
//
// Drains a byte FIFO onto a UART serial line using 8N1 framing: one start
// bit (low), eight data bits sent LSB first, one stop bit (high). Each bit
// is held for CLK_PER_BIT clock cycles.
//
// The FIFO is assumed to have a registered (BRAM-style) read port: the head
// byte on fifo_read_data is only trustworthy one full cycle after
// fifo_read_ready rises or after the previous pop. A one-cycle WAIT state
// gives it that settling time before FETCH samples it and pops.
//
// Per byte the sequence is
//   IDLE -> WAIT -> FETCH -> START -> DATA x8 -> STOP -> IDLE
// which makes a frame exactly 10*CLK_PER_BIT cycles long, with three extra
// high cycles (IDLE, WAIT, FETCH) between back-to-back frames.
//
// Parameters
//   CLK_PER_BIT     clk cycles per UART bit, legal range 2..65535
//                   (default 868 = 100 MHz / 115200 baud)
//   DATA_BITWIDTH   byte width read from the FIFO; 8 for 8N1 framing
//
// Ports
//   clk               single clock, all state changes on its rising edge
//   reset_n           asynchronous active-low reset
//   fifo_read_ready   FIFO non-empty flag
//   fifo_read_data    FIFO head byte (registered read port)
//   fifo_read_enable  one-cycle pop strobe, high only during FETCH
//   txd               UART serial output, idle high
//   busy              high whenever a byte is being fetched or serialized
// -----------------------------------------------------------------------------
module uart_tx_drain #(
    parameter int CLK_PER_BIT   = 868,
    parameter int DATA_BITWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fifo_read_ready,
    input  logic [DATA_BITWIDTH-1:0] fifo_read_data,
    output logic                     fifo_read_enable,
    output logic                     txd,
    output logic                     busy
);

    // Baud counter just wide enough for 0..CLK_PER_BIT-1; it is cleared on
    // every bit boundary so it can never wrap in the middle of a bit.
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITWIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FETCH,
        START,
        DATA,
        STOP
    } state_e;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         baud_q, baud_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DATA_BITWIDTH-1:0] shift_q, shift_d;

    logic txd_q, txd_d;
    logic rd_en_q, rd_en_d;
    logic busy_q, busy_d;

    logic bit_done;

    // Last cycle of the current START, DATA or STOP bit.
    assign bit_done = (baud_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts from its held value so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        unique case (state_q)
            IDLE: begin
                if (fifo_read_ready) begin
                    state_d = WAIT;
                end
            end

            // Gives the registered FIFO read port one full cycle to present
            // the head byte before it is sampled.
            WAIT: begin
                state_d = FETCH;
            end

            // The only cycle in which fifo_read_data is looked at.
            FETCH: begin
                shift_d = fifo_read_data;
                baud_d  = '0;
                idx_d   = '0;
                state_d = START;
            end

            START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            // Bit 0 of the shift register is always the bit on the line;
            // shifting right at each boundary exposes the next one (LSB first).
            DATA: begin
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that, once registered, they
    // line up exactly with the state they belong to.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign rd_en_d = (state_d == FETCH);
    assign busy_d  = (state_d != IDLE);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the shift register and counters are reset along with the
        // state so an aborted frame leaves nothing behind for the next byte.
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
        end
    end

    assign txd              = txd_q;
    assign fifo_read_enable = rd_en_q;
    assign busy             = busy_q;

    // -------------------------------------------------------------------------
    // Protocol properties
    // -------------------------------------------------------------------------
    // The pop strobe is a single-cycle pulse.
    a_single_pop: assert property (
        @(posedge clk) disable iff (!reset_n)
        fifo_read_enable |=> !fifo_read_enable
    );

    // A pop only happens while a byte is being handled.
    a_pop_when_busy: assert property (
        @(posedge clk) disable iff (!reset_n)
        fifo_read_enable |-> busy
    );

    // The line is idle high whenever nothing is in progress.
    a_idle_high: assert property (
        @(posedge clk) disable iff (!reset_n)
        !busy |-> txd
    );

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_BITWIDTH, default 8, giving the byte width read from the FIFO; fixed at 8 for 8N1 framing.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port fifo_read_ready, input, 1, FIFO non-empty flag.
REQ-006 The block SHALL have port fifo_read_data, input, 8, FIFO head byte; registered BRAM output, valid one full cycle after fifo_read_ready rises or after the previous pop.
REQ-007 The block SHALL have port fifo_read_enable, output, 1, a one-cycle pop strobe to the FIFO.
REQ-008 The block SHALL have port txd, output, 1, the UART serial line; idle high.
REQ-009 The block SHALL have port busy, output, 1, high while a byte is being fetched or serialized.

Function
REQ-010 The FSM SHALL have states IDLE, WAIT, FETCH, START, DATA, STOP.
REQ-011 In IDLE, fifo_read_ready=1 SHALL move the FSM to WAIT; otherwise it stays in IDLE.
REQ-012 WAIT SHALL last exactly 1 cycle and then go unconditionally to FETCH, so that fifo_read_data has settled.
REQ-013 In FETCH (1 cycle), fifo_read_enable SHALL be 1, fifo_read_data SHALL be latched into an 8-bit shift register, and the next state SHALL be START.
REQ-014 fifo_read_enable SHALL be a decode of FETCH only: exactly one pulse per byte and never asserted in any other state.
REQ-015 txd SHALL be registered: 0 in START, shift register bit 0 in DATA, and 1 in STOP and IDLE/WAIT/FETCH.
REQ-016 Each of START, each DATA bit, and STOP SHALL hold txd for exactly CLK_PER_BIT cycles, counted by a baud counter that is cleared on every bit boundary.
REQ-017 DATA SHALL send bit 0 first (LSB first): 8 bits, a 3-bit index, and the shift register shifted right once per bit boundary.
REQ-018 After the 8th data bit the FSM SHALL go to STOP; at the end of STOP it SHALL return to IDLE.
REQ-019 A frame SHALL occupy exactly 10*CLK_PER_BIT cycles with txd low for the START bit.
REQ-020 Back-to-back bytes SHALL be separated by exactly 3 extra high cycles (IDLE, WAIT, FETCH) after the stop bit.
REQ-021 fifo_read_ready falling during START/DATA/STOP SHALL have no effect on the frame in flight.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 The baud counter SHALL be at least $clog2(CLK_PER_BIT) bits wide and SHALL never wrap mid-bit.
REQ-024 fifo_read_data SHALL be ignored outside FETCH.

Reset
REQ-025 While reset_n=0 the block SHALL immediately (asynchronously) hold state=IDLE, txd=1, fifo_read_enable=0, busy=0, and counters/shift register=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further pop; after release the block SHALL resume from IDLE with the next FIFO byte.

Verification (CLK_PER_BIT=4)
REQ-027 FIFO empty for 100 cycles -> txd=1, fifo_read_enable=0, busy=0 throughout.
REQ-028 Push 0x55 -> one fifo_read_enable pulse; txd = 0,1,0,1,0,1,0,1,0,1, each level 4 cycles; busy falls after 40 txd cycles.
REQ-029 Push 0xA3 then 0x0F consecutively -> frames 0,1,1,0,0,0,1,0,1,1 and 0,1,1,1,1,0,0,0,0,1 with exactly 3 high cycles between them; 2 pops total.
REQ-030 Assert reset_n=0 during data bit 3 of 0xFF -> txd=1 in the same cycle; after release, the next queued byte 0x81 is sent intact.
REQ-031 Push a byte exactly as the previous stop bit ends -> txd start bit falls 3 cycles after stop end, and the correct byte is sent (no stale fifo_read_data).
